// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
// Multi-digit BCD event counter with time-multiplexed digit scanning for a
// shared BCD-to-7-segment decoder. Each scan slot presents one digit on
// W,X,Y,Z and pulls one active-low digit-select line.
//
// Optional feature macro: LEADING_BLANK_EN
//   defined   -> leading zero digits (other than digit 0) output 4'b1111 so the
//                decoder blanks them
//   undefined -> every digit always shows its BCD value
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic              W,
    output logic              X,
    output logic              Y,
    output logic              Z,
    output logic [DIGITS-1:0] dig_n,
    output logic              carry
);

    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    // Counter state
    logic [3:0]        digit_r [DIGITS];
    logic [3:0]        digit_nxt_s [DIGITS];
    logic              ripple_s;
    logic              wrap_s;

    // Scan state
    logic [PRE_W-1:0]  pre_r;
    logic [SLOT_W-1:0] slot_r;

    // Output registers
    logic [3:0]        nib_r;
    logic [DIGITS-1:0] dig_n_r;
    logic              carry_r;

    // Scan-side combinational values (from pre-edge slot and digits)
    logic [3:0]        nib_s;
    logic [DIGITS-1:0] sel_n_s;

`ifdef LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_s;
    logic              hi_zero_s;
`endif

    // Next digit values: inc ripples through 9s in one edge; clr overrides inc.
    always_comb begin
        ripple_s = inc;
        wrap_s   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_nxt_s[i] = digit_r[i];
            if (ripple_s) begin
                if (digit_r[i] >= 4'd9) begin
                    // Values above 9 cannot occur; treat them like 9 so the
                    // digit always re-enters the legal range.
                    digit_nxt_s[i] = 4'd0;
                end else begin
                    digit_nxt_s[i] = digit_r[i] + 4'd1;
                    ripple_s       = 1'b0;
                end
            end else begin
                digit_nxt_s[i] = digit_r[i];
            end
        end
        if (clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_nxt_s[i] = 4'd0;
            end
            wrap_s = 1'b0;
        end else begin
            // Ripple surviving past the top digit means all digits were 9.
            wrap_s = ripple_s;
        end
    end

`ifdef LEADING_BLANK_EN
    // Mark digits that are zero along with every digit above them; digit 0 never blanks.
    always_comb begin
        hi_zero_s = 1'b1;
        blank_s   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero_s  = hi_zero_s & (digit_r[i] == 4'd0);
            blank_s[i] = hi_zero_s & (i != 0);
        end
    end
`endif

    // Select the scanned digit's nibble and its one-cold select pattern.
    always_comb begin
        nib_s   = 4'd0;
        sel_n_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_r == SLOT_W'(i)) begin
`ifdef LEADING_BLANK_EN
                nib_s = blank_s[i] ? 4'b1111 : digit_r[i];
`else
                nib_s = digit_r[i];
`endif
                sel_n_s[i] = 1'b0;
            end else begin
                sel_n_s[i] = 1'b1;
            end
        end
    end

    // Count register and wrap pulse; reset discards any pending inc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_r[i] <= 4'd0;
            end
            carry_r <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_r[i] <= digit_nxt_s[i];
            end
            carry_r <= wrap_s;
        end
    end

    // Prescaler and scan slot; independent of clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_r  <= '0;
            slot_r <= '0;
        end else if (pre_r == PRE_LAST) begin
            pre_r  <= '0;
            slot_r <= (slot_r == SLOT_LAST) ? '0 : slot_r + SLOT_W'(1);
        end else begin
            pre_r  <= pre_r + PRE_W'(1);
            slot_r <= slot_r;
        end
    end

    // Nibble and digit select load together so the display never ghosts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib_r   <= 4'd0;
            dig_n_r <= '1;
        end else begin
            nib_r   <= nib_s;
            dig_n_r <= sel_n_s;
        end
    end

    assign W     = nib_r[3];
    assign X     = nib_r[2];
    assign Y     = nib_r[1];
    assign Z     = nib_r[0];
    assign dig_n = dig_n_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Testbench for bcd_scan_counter: two instances (SCAN_DIV=1 and SCAN_DIV=4,
// both DIGITS=4) share stimulus and are compared every cycle against an
// arithmetic model holding the count as an integer.
module tb_bcd_scan_counter;

    localparam int ND  = 4;
    localparam int MOD = 10000;

    logic clk = 1'b0;
    logic rst_n;
    logic inc;
    logic clr;

    logic          w0, x0, y0, z0, carry0;
    logic [ND-1:0] dig0;
    logic          w1, x1, y1, z1, carry1;
    logic [ND-1:0] dig1;

    int errors = 0;
    int checks = 0;

    // Model state
    int cnt;   // count value as integer
    int e;     // non-reset edges since last reset

    logic [3:0]    exp_n0, exp_n1;
    logic [ND-1:0] exp_d0, exp_d1;
    logic          exp_c;

    bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(1)) u0 (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
        .W(w0), .X(x0), .Y(y0), .Z(z0), .dig_n(dig0), .carry(carry0)
    );

    bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(4)) u1 (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
        .W(w1), .X(x1), .Y(y1), .Z(z1), .dig_n(dig1), .carry(carry1)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // What the display shows for slot s given count c.
    function automatic logic [3:0] disp(input int c, input int s);
`ifdef LEADING_BLANK_EN
        if (s > 0 && c < pow10(s)) return 4'b1111;
`endif
        return 4'((c / pow10(s)) % 10);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cnt=%0d e=%0d)", tag, got, expv, cnt, e);
        end
    endtask

    // One clock: apply inputs, advance model, compare outputs after the edge.
    task automatic step(input logic i_inc, input logic i_clr, input logic i_rst);
        int s0, s1;
        inc   = i_inc;
        clr   = i_clr;
        rst_n = ~i_rst;
        @(posedge clk);
        if (i_rst) begin
            cnt    = 0;
            e      = 0;
            exp_n0 = 4'd0;
            exp_n1 = 4'd0;
            exp_d0 = 4'b1111;
            exp_d1 = 4'b1111;
            exp_c  = 1'b0;
        end else begin
            s0     = e % ND;
            s1     = (e / 4) % ND;
            exp_n0 = disp(cnt, s0);
            exp_n1 = disp(cnt, s1);
            exp_d0 = ~(4'b0001 << s0);
            exp_d1 = ~(4'b0001 << s1);
            exp_c  = !i_clr && i_inc && (cnt == MOD - 1);
            if (i_clr)      cnt = 0;
            else if (i_inc) cnt = (cnt + 1) % MOD;
            e++;
        end
        #1;
        chk("nib0",   {4'd0, w0, x0, y0, z0}, {4'd0, exp_n0});
        chk("dign0",  {4'd0, dig0},           {4'd0, exp_d0});
        chk("carry0", {7'd0, carry0},         {7'd0, exp_c});
        chk("nib1",   {4'd0, w1, x1, y1, z1}, {4'd0, exp_n1});
        chk("dign1",  {4'd0, dig1},           {4'd0, exp_d1});
        chk("carry1", {7'd0, carry1},         {7'd0, exp_c});
    endtask

    initial begin
        cnt = 0;
        e   = 0;
        inc = 1'b0;
        clr = 1'b0;
        rst_n = 1'b0;

        // Reset for two edges, then release.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Ten inc pulses, then let the scan cycle a few times.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

        // Random inc/clr traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), 1'b0);

        // Count 0042, then clr and inc together.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 42; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);

        // Climb to 9999, wrap once, and observe carry for one cycle only.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MOD - 1; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        // Back to 9999 and wrap with inc held high across the wrap.
        for (int i = 0; i < MOD + 3; i++) step(1'b1, 1'b0, 1'b0);

        // Reset mid-operation with inc high, then resume.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
